// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit sitting in front of the Datapath.
// Latches the fetched instruction, decodes it and steps it through
// FETCH/DECODE/EXEC/MEM/WBACK while driving the Datapath control lines.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   Instr      instruction from the fetch path (sampled in FETCH)
//   Status     ALU flags {N,Z,C,V}; C=1 means A>=B unsigned
//   mem_ready  data memory completes the access this cycle
//   imm_sel    immediate format: 00 I/load, 01 S, 10 B
//   RegRW      register-file write enable (WBACK only)
//   ALUsrc     1 = immediate as ALU operand B
//   ALUop      ALU operation code
//   MRW        data memory write enable (store, MEM only)
//   WB         1 = ALU result, 0 = memory data to register file
//   PCsrc      1 = branch target selected
//   pc_en      PC update strobe, last cycle of each instruction
//   state      current state code
//   fault      00 none, 01 illegal instruction, 10 memory timeout
//
// state | meaning
// ------+-------------------------------------------------
// 0     | FETCH  : latch Instr into IR
// 1     | DECODE : check opcode, decoded fields become valid
// 2     | EXEC   : ALU op; branches resolve and finish here
// 3     | MEM    : data memory access, waits on mem_ready
// 4     | WBACK  : register-file write, PC update
// 5     | HALT   : fault parking state, left only by reset

module control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  Status,
    input  logic        mem_ready,
    output logic [1:0]  imm_sel,
    output logic        RegRW,
    output logic        ALUsrc,
    output logic [3:0]  ALUop,
    output logic        MRW,
    output logic        WB,
    output logic        PCsrc,
    output logic        pc_en,
    output logic [2:0]  state,
    output logic [1:0]  fault
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WBACK  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_SUB  = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [31:0]      ir;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       state_nxt;
    logic [1:0]       fault_nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_ld, is_st, is_br, legal, taken;
    logic [1:0] dec_imm;
    logic       dec_src, dec_wb;
    logic [3:0] dec_op;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_fn = alt ? OP_SUB : OP_ADD;
            3'b001:  alu_fn = OP_SLL;
            3'b010:  alu_fn = OP_SLT;
            3'b011:  alu_fn = OP_SLTU;
            3'b100:  alu_fn = OP_XOR;
            3'b101:  alu_fn = alt ? OP_SRA : OP_SRL;
            3'b110:  alu_fn = OP_OR;
            default: alu_fn = OP_AND;
        endcase
    endfunction

    always_comb begin
        is_r  = (opcode == 7'b0110011);
        is_i  = (opcode == 7'b0010011);
        is_ld = (opcode == 7'b0000011) && (funct3 == 3'b010);
        is_st = (opcode == 7'b0100011) && (funct3 == 3'b010);
        is_br = (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);
        legal = is_r | is_i | is_ld | is_st | is_br;

        dec_imm = is_st ? 2'b01 : (is_br ? 2'b10 : 2'b00);
        dec_src = is_i | is_ld | is_st;
        dec_wb  = ~is_ld;
        if (is_r)
            dec_op = alu_fn(funct3, ir[30]);
        else if (is_i)
            // I-ALU funct3 000 has no SUB form; bit 30 is part of the immediate
            dec_op = (funct3 == 3'b000) ? OP_ADD : alu_fn(funct3, ir[30]);
        else if (is_br)
            dec_op = OP_SUB;
        else
            dec_op = OP_ADD;

        // Status = {N,Z,C,V}
        case (funct3)
            3'b000:  taken = Status[2];
            3'b001:  taken = ~Status[2];
            3'b100:  taken = Status[3] ^ Status[0];
            3'b101:  taken = ~(Status[3] ^ Status[0]);
            3'b110:  taken = ~Status[1];
            3'b111:  taken = Status[1];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            ir    <= '0;
            fault <= 2'b00;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            fault <= fault_nxt;
            cnt   <= cnt_nxt;
            if (state == S_FETCH)
                ir <= Instr;
        end
    end

    always_comb begin
        state_nxt = state;
        fault_nxt = fault;
        cnt_nxt   = cnt;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (legal) begin
                    state_nxt = S_EXEC;
                end else begin
                    state_nxt = S_HALT;
                    fault_nxt = 2'b01;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    state_nxt = S_FETCH;
                end else if (is_ld || is_st) begin
                    state_nxt = S_MEM;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_WBACK;
                end
            end
            S_MEM: begin
                // a ready on the last allowed cycle still completes the access
                if (mem_ready) begin
                    state_nxt = is_ld ? S_WBACK : S_FETCH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HALT;
                    fault_nxt = 2'b10;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WBACK: state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        imm_sel = 2'b00;
        ALUsrc  = 1'b0;
        ALUop   = OP_ADD;
        WB      = 1'b1;
        RegRW   = 1'b0;
        MRW     = 1'b0;
        PCsrc   = 1'b0;
        pc_en   = 1'b0;
        if (legal && (state == S_DECODE || state == S_EXEC ||
                      state == S_MEM || state == S_WBACK)) begin
            imm_sel = dec_imm;
            ALUsrc  = dec_src;
            ALUop   = dec_op;
            WB      = dec_wb;
        end
        case (state)
            S_EXEC: begin
                if (is_br) begin
                    pc_en = 1'b1;
                    PCsrc = taken;
                end
            end
            S_MEM: begin
                MRW   = is_st;
                pc_en = is_st & mem_ready;
            end
            S_WBACK: begin
                RegRW = 1'b1;
                pc_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  Status;
    logic        mem_ready;
    logic [1:0]  imm_sel;
    logic        RegRW, ALUsrc, MRW, WB, PCsrc, pc_en;
    logic [3:0]  ALUop;
    logic [2:0]  state;
    logic [1:0]  fault;

    control_fsm #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Status(Status),
        .mem_ready(mem_ready), .imm_sel(imm_sel), .RegRW(RegRW),
        .ALUsrc(ALUsrc), .ALUop(ALUop), .MRW(MRW), .WB(WB), .PCsrc(PCsrc),
        .pc_en(pc_en), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [3:0]  status;
        logic        mr;
        logic [2:0]  st;
        logic [1:0]  flt;
        logic [1:0]  imm;
        logic        rw;
        logic        asrc;
        logic [3:0]  aop;
        logic        mrw;
        logic        wb;
        logic        pcs;
        logic        pce;
    } vec_t;

    localparam logic [31:0] ADDI  = 32'h00450693;
    localparam logic [31:0] SW    = 32'hFE322FA3;
    localparam logic [31:0] LW    = 32'h0006A803;
    localparam logic [31:0] BLTU  = 32'h00B76063;
    localparam logic [31:0] BGE   = 32'h00B75063;
    localparam logic [31:0] BEQ   = 32'h00B70063;
    localparam logic [31:0] SUB   = 32'h403100B3;
    localparam logic [31:0] SRAI  = 32'h40515093;
    localparam logic [31:0] ADDIN = 32'hC0010093;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] BILL  = 32'h00B72063;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [31:0] instr,
                                input logic [3:0] status, input logic mr,
                                input logic [2:0] st, input logic [1:0] flt,
                                input logic [1:0] imm, input logic rw,
                                input logic asrc, input logic [3:0] aop,
                                input logic mrw, input logic wb,
                                input logic pcs, input logic pce);
        vec_t v;
        v.rst = rst; v.instr = instr; v.status = status; v.mr = mr;
        v.st = st; v.flt = flt; v.imm = imm; v.rw = rw; v.asrc = asrc;
        v.aop = aop; v.mrw = mrw; v.wb = wb; v.pcs = pcs; v.pce = pce;
        return v;
    endfunction

    // idle/reset-valued outputs in a given state with a given fault
    function automatic vec_t idle(input logic rst, input logic [31:0] instr,
                                  input logic [2:0] st, input logic [1:0] flt);
        return mk(rst, instr, 4'h0, 1'b1, st, flt, 2'b00, 1'b0, 1'b0, 4'b0100,
                  1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        logic [16:0] got, exp;
        @(negedge clk);
        reset     = v.rst;
        Instr     = v.instr;
        Status    = v.status;
        mem_ready = v.mr;
        #1;
        got = {state, fault, imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, pc_en};
        exp = {v.st, v.flt, v.imm, v.rw, v.asrc, v.aop, v.mrw, v.wb, v.pcs, v.pce};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got {st,flt,imm,rw,src,op,mrw,wb,pcs,pce}=%b_%b_%b_%b_%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b_%b_%b_%b_%b",
                     name, n_vec, state, fault, imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, pc_en,
                     v.st, v.flt, v.imm, v.rw, v.asrc, v.aop, v.mrw, v.wb, v.pcs, v.pce);
        end
    endtask

    task automatic push_alu(input logic [31:0] instr, input logic asrc, input logic [3:0] aop);
        tbl.push_back(idle(1'b1, instr, 3'd0, 2'b00));
        tbl.push_back(mk(1, instr, 0, 1, 3'd1, 2'b00, 2'b00, 0, asrc, aop, 0, 1, 0, 0));
        tbl.push_back(mk(1, instr, 0, 1, 3'd2, 2'b00, 2'b00, 0, asrc, aop, 0, 1, 0, 0));
        tbl.push_back(mk(1, instr, 0, 1, 3'd4, 2'b00, 2'b00, 1, asrc, aop, 0, 1, 0, 1));
    endtask

    task automatic push_br(input logic [31:0] instr, input logic [3:0] status, input logic tk);
        tbl.push_back(idle(1'b1, instr, 3'd0, 2'b00));
        tbl.push_back(mk(1, instr, status, 1, 3'd1, 2'b00, 2'b10, 0, 0, 4'b1100, 0, 1, 0, 0));
        tbl.push_back(mk(1, instr, status, 1, 3'd2, 2'b00, 2'b10, 0, 0, 4'b1100, 0, 1, tk, 1));
    endtask

    initial begin
        reset = 1'b0; Instr = '0; Status = '0; mem_ready = 1'b1;

        tbl.push_back(idle(1'b0, ADDI, 3'd0, 2'b00));
        push_alu(ADDI, 1'b1, 4'b0100);
        // store, two not-ready cycles then ready
        tbl.push_back(idle(1'b1, SW, 3'd0, 2'b00));
        tbl.push_back(mk(1, SW, 0, 1, 3'd1, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 1, 3'd2, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 0, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 0, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 1, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 1));
        // load, immediate ready
        tbl.push_back(idle(1'b1, LW, 3'd0, 2'b00));
        tbl.push_back(mk(1, LW, 0, 1, 3'd1, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 1, 3'd2, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 1, 3'd3, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 1, 3'd4, 0, 2'b00, 1, 1, 4'b0100, 0, 0, 0, 1));
        // branches, Status = {N,Z,C,V}
        push_br(BLTU, 4'b0000, 1'b1);
        push_br(BLTU, 4'b0010, 1'b0);
        push_br(BGE,  4'b1000, 1'b0);
        push_br(BEQ,  4'b0100, 1'b1);
        push_alu(SUB,   1'b0, 4'b1100);
        push_alu(SRAI,  1'b1, 4'b0111);
        push_alu(ADDIN, 1'b1, 4'b0100);
        // reset asserted in the middle of a store's MEM wait
        tbl.push_back(idle(1'b1, SW, 3'd0, 2'b00));
        tbl.push_back(mk(1, SW, 0, 0, 3'd1, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 0, 3'd2, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0));
        tbl.push_back(mk(1, SW, 0, 0, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 0));
        tbl.push_back(idle(1'b0, ADDI, 3'd0, 2'b00));
        push_alu(ADDI, 1'b1, 4'b0100);

        foreach (tbl[i]) run_vec(tbl[i], "table");

        // illegal opcode parks in HALT with all enables low
        run_vec(idle(1'b0, ILL, 3'd0, 2'b00), "ill_reset");
        run_vec(idle(1'b1, ILL, 3'd0, 2'b00), "ill_fetch");
        run_vec(idle(1'b1, ILL, 3'd1, 2'b00), "ill_decode");
        for (int i = 0; i < 10; i++) run_vec(idle(1'b1, ILL, 3'd5, 2'b01), "ill_halt");

        // branch opcode with a reserved funct3 is illegal
        run_vec(idle(1'b0, BILL, 3'd0, 2'b00), "bill_reset");
        run_vec(idle(1'b1, BILL, 3'd0, 2'b00), "bill_fetch");
        run_vec(idle(1'b1, BILL, 3'd1, 2'b00), "bill_decode");
        run_vec(idle(1'b1, BILL, 3'd5, 2'b01), "bill_halt");

        // load never ready: 15 MEM cycles then timeout fault
        run_vec(idle(1'b0, LW, 3'd0, 2'b00), "to_reset");
        run_vec(idle(1'b1, LW, 3'd0, 2'b00), "to_fetch");
        run_vec(mk(1, LW, 0, 0, 3'd1, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0), "to_decode");
        run_vec(mk(1, LW, 0, 0, 3'd2, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0), "to_exec");
        for (int i = 0; i < 15; i++)
            run_vec(mk(1, LW, 0, 0, 3'd3, 0, 2'b00, 0, 1, 4'b0100, 0, 0, 0, 0), "to_mem");
        for (int i = 0; i < 3; i++) begin
            vec_t h;
            h = idle(1'b1, LW, 3'd5, 2'b10);
            h.mr = 1'b0;
            run_vec(h, "to_halt");
        end

        // store ready on the last allowed MEM cycle completes without fault
        run_vec(idle(1'b0, SW, 3'd0, 2'b00), "edge_reset");
        run_vec(idle(1'b1, SW, 3'd0, 2'b00), "edge_fetch");
        run_vec(mk(1, SW, 0, 0, 3'd1, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0), "edge_decode");
        run_vec(mk(1, SW, 0, 0, 3'd2, 0, 2'b01, 0, 1, 4'b0100, 0, 1, 0, 0), "edge_exec");
        for (int i = 0; i < 14; i++)
            run_vec(mk(1, SW, 0, 0, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 0), "edge_wait");
        run_vec(mk(1, SW, 0, 1, 3'd3, 0, 2'b01, 0, 1, 4'b0100, 1, 1, 0, 1), "edge_ready");
        run_vec(idle(1'b1, SW, 3'd0, 2'b00), "edge_next");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
